keypad_scan: RTL
================

Name: keypad_scan

Overview:
- Scans a 4x4 matrix hex keypad and debounces it. Delivers entered hex digits to the RISC-V core as a 16-bit shift-register value plus a per-key strobe.
- It is the input-side counterpart of the 7-seg dynamic display driver: time-multiplexed column drive out, row sense in.
- Sits in top beside the display driver. data_key and key_valid feed the core.

Parameters:
- SCAN_DIV, 100000: clocks per column slot (1 ms at 100 MHz); legal range >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full frames required to accept a press or a release; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- row  input  4  keypad row sense, active-low, externally pulled up; asynchronous to clk.
- col  output  4  column drive, active-low, exactly one bit low at any time.
- key_code  output  4  code of last accepted key.
- key_valid  output  1  one-cycle strobe per accepted key.
- data_key  output  16  last four accepted codes; newest in [3:0].

Behaviour:
- Reset (rst low, asynchronous) clears the following:
  - col=4'b1110; column index 0; divider 0.
  - row synchroniser flops = 4'b1111.
  - key_code=0, key_valid=0, data_key=0.
  - state IDLE, counters 0, frame accumulators cleared.
- Reset mid-scan or mid-debounce discards all progress. No strobe is issued.
- row passes through a 2-flop synchroniser. All logic uses only the synchronised value.
- Divider counts 0..SCAN_DIV-1.
  - At the terminal count, the synchronised row is sampled for the current column.
  - Column index then advances c -> c+1 mod 4, and col = ~(1<<c).
- Frame = 4 column slots (4*SCAN_DIV clocks). It ends at the terminal count of column 3.
- Per-frame classification:
  - Count active (low) row bits over all 4 samples.
  - 0 active -> NONE.
  - Exactly 1 active at (row r, column c) -> KEY with code = 4*r + c.
  - >1 active -> MULTI, treated as NONE (ghost/rollover rejection).
- Debounce FSM is evaluated once per frame end. cnt is 4 bits.
  - IDLE: KEY k -> DEBOUNCE, cand=k, cnt=1. Otherwise stay.
  - DEBOUNCE:
    - KEY k with k==cand: cnt+1.
    - KEY k with k!=cand: cand=k, cnt=1.
    - NONE/MULTI: -> IDLE.
    - When cnt reaches DEBOUNCE_SCANS: accept cand and go to HELD. With DEBOUNCE_SCANS=1, accept on the first KEY frame directly from IDLE.
  - HELD:
    - NONE frame -> RELEASE, cnt=1.
    - Any KEY/MULTI frame: stay.
    - No auto-repeat.
  - RELEASE:
    - NONE: cnt+1. When cnt reaches DEBOUNCE_SCANS -> IDLE.
    - KEY/MULTI -> HELD (bounce).
- Accept action, registered on the clock edge after the frame-end sample:
  - key_valid=1 for exactly one cycle.
  - key_code=cand.
  - data_key={data_key[11:0], cand}.
- key_code and data_key hold between accepts.
- A new key can only be accepted after a full release to IDLE.
- Latency: the strobe is asserted 1 clk after the terminal count of the DEBOUNCE_SCANS-th qualifying frame. Add 2 clks of synchroniser delay on row edges.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, frame=16 clks):
- Reset: hold rst low, then release.
  - col==4'b1110, data_key==0, key_valid==0.
  - col rotates 1110->1101->1011->0111 every 4 clks.
- Press key r=2, c=1 (row[2] low whenever col[1] low), held steady.
  - Exactly one key_valid pulse after the 2nd full frame.
  - key_code==4'h9, data_key==16'h0009.
  - No further pulses while held.
- Enter keys 1, 2, 3, A in sequence, with a release (>=2 NONE frames) between each.
  - Four pulses; data_key==16'h123A, key_code==4'hA.
- Bounce: key 5 present in 1 frame, absent 1 frame, present 1 frame, then released.
  - No key_valid; state returns to IDLE.
- Two keys (0 and 7) pressed together for 4 frames.
  - No pulse (MULTI rejected).
  - Then release key 7 while keeping 0 for 2 frames -> pulse with key_code==0.
- Assert rst low mid-DEBOUNCE (after 1 qualifying frame).
  - Outputs return to reset values immediately.
  - The next press needs 2 fresh frames.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad scanner with frame-based debounce.
//   Drives one active-low column per slot, senses active-low rows, classifies
//   each full 4-column frame (NONE / single KEY / MULTI) and debounces the
//   result. Each accepted key produces a one-cycle strobe and is shifted into
//   a 16-bit register of the last four codes.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   row[3:0]  row sense, active-low, asynchronous to clk
//   col[3:0]  column drive, active-low, exactly one bit low
//   key_code  code (4*row + col) of the last accepted key
//   key_valid one-cycle strobe per accepted key
//   data_key  last four accepted codes, newest in [3:0]
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] data_key
);

  localparam int                DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]        DEB_N    = 4'(DEBOUNCE_SCANS);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [3:0]       row_p0, row_p1;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       acc_n;      // active samples so far this frame, saturates at 2
  logic [3:0]       acc_code;
  logic [1:0]       state, state_n;
  logic [3:0]       cand, cand_n;
  logic [3:0]       cnt, cnt_n;

  logic [3:0]       act;
  logic [2:0]       n_now;
  logic [1:0]       r_now;
  logic [2:0]       sum_n;
  logic [3:0]       merged_code;
  logic             slot_end, frame_end, frame_key, frame_none;
  logic             accept;
  logic [3:0]       accept_code;

  assign col = ~(4'b0001 << col_idx);

  // Stage p0/p1: two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_p0 <= 4'b1111;
      row_p1 <= 4'b1111;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
    end
  end

  // Column slot timing and per-sample classification
  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (col_idx == 2'd3);
  assign act       = ~row_p1;

  always_comb begin
    n_now = 3'd0;
    r_now = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      n_now = n_now + 3'(act[i]);
      if (act[i]) r_now = 2'(i);
    end
    sum_n       = 3'(acc_n) + n_now;
    // When the frame total is exactly one, the lone hit is either already
    // in the accumulator or in this sample.
    merged_code = (acc_n == 2'd0) ? {r_now, col_idx} : acc_code;
    frame_key   = frame_end && (sum_n == 3'd1);
    frame_none  = frame_end && (sum_n == 3'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      col_idx  <= 2'd0;
      acc_n    <= 2'd0;
      acc_code <= 4'd0;
    end else if (slot_end) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
      if (col_idx == 2'd3) begin
        acc_n    <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_n    <= (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        acc_code <= merged_code;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Debounce FSM, advanced only at frame end
  always_comb begin
    state_n     = state;
    cand_n      = cand;
    cnt_n       = cnt;
    accept      = 1'b0;
    accept_code = cand;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (frame_key) begin
            if (DEB_N == 4'd1) begin
              accept      = 1'b1;
              accept_code = merged_code;
              cand_n      = merged_code;
              cnt_n       = 4'd0;
              state_n     = HELD;
            end else begin
              cand_n  = merged_code;
              cnt_n   = 4'd1;
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!frame_key) begin
            cnt_n   = 4'd0;
            state_n = IDLE;
          end else if (merged_code != cand) begin
            cand_n = merged_code;
            cnt_n  = 4'd1;
          end else if (cnt + 4'd1 == DEB_N) begin
            accept  = 1'b1;
            cnt_n   = 4'd0;
            state_n = HELD;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        HELD: begin
          if (frame_none) begin
            if (DEB_N == 4'd1) begin
              cnt_n   = 4'd0;
              state_n = IDLE;
            end else begin
              cnt_n   = 4'd1;
              state_n = RELEASE;
            end
          end
        end
        default: begin
          if (!frame_none) begin
            cnt_n   = 4'd0;
            state_n = HELD;
          end else if (cnt + 4'd1 == DEB_N) begin
            cnt_n   = 4'd0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  // Output stage: strobe and code history registered on the frame-end edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      data_key  <= 16'd0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= accept_code;
        data_key <= {data_key[11:0], accept_code};
      end
    end
  end

endmodule
